hs4_responder: RTL and testbench

- Passive (responder) end of a four-phase return-to-zero bundled-data channel, in the same cycle-based style as the C-element and SR gate models.
- Samples REQ/DIN on CK, drives ACK, and buffers accepted words in a small FIFO.
- Presents buffered words to a synchronous consumer over a valid/ready interface.
- Detects and records four-phase protocol violations by the initiator.

---
 rtl/hs4_responder.sv | 127 ++++++++++++
 tb/tb_hs4_responder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hs4_responder.sv
// hs4_responder: passive end of a four-phase return-to-zero bundled-data channel.
// REQ/DIN are sampled on CK. ACK is driven back to the initiator. Accepted words are
// buffered in a small FIFO and handed to a synchronous consumer over valid/ready.
// Ports:
//   CK, RS          clock, asynchronous active-high reset
//   ENA             global enable; 0 freezes all state and blocks pops
//   REQ, DIN        four-phase request and bundled data from the initiator
//   ACK             registered acknowledge
//   ACK_NEXT        value ACK takes at the next enabled edge
//   DOUT            FIFO head word (0 when empty)
//   DOUT_VALID      head word available
//   DOUT_READY      consumer accepts head
//   COUNT           FIFO occupancy
//   ERR             sticky flag: REQ withdrawn before ACK
module hs4_responder #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ACK_DELAY = 0
) (
   input  logic                       CK,
   input  logic                       RS,
   input  logic                       ENA,
   input  logic                       REQ,
   input  logic [WIDTH-1:0]           DIN,
   output logic                       ACK,
   output logic                       ACK_NEXT,
   output logic [WIDTH-1:0]           DOUT,
   output logic                       DOUT_VALID,
   input  logic                       DOUT_READY,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       ERR
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [3:0] DELAY_INIT = 4'(ACK_DELAY);

   typedef enum logic [1:0] {StIdle, StDelay, StAcked} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             ack_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push, pop;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      push    = 1'b0;
      if (ENA) begin
         unique case (state_q)
            StIdle: begin
               // Full FIFO withholds ACK: the initiator simply waits in REQ=1.
               if (REQ && count_q != FULL) begin
                  push = 1'b1;
                  if (ACK_DELAY == 0) begin
                     state_d = StAcked;
                  end else begin
                     cnt_d   = DELAY_INIT;
                     state_d = StDelay;
                  end
               end
            end
            StDelay: begin
               if (!REQ) begin
                  // Word already pushed stays in the FIFO.
                  err_d   = 1'b1;
                  cnt_d   = 4'd0;
                  state_d = StIdle;
               end else if (cnt_q == 4'd1) begin
                  cnt_d   = 4'd0;
                  state_d = StAcked;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            StAcked: begin
               if (!REQ) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign ACK_NEXT   = (state_d == StAcked);
   assign ACK        = ack_q;
   assign ERR        = err_q;
   assign COUNT      = count_q;
   assign DOUT_VALID = (count_q != '0) && ENA;
   assign pop        = DOUT_VALID && DOUT_READY;
   assign DOUT       = (count_q != '0) ? mem[rd_ptr_q] : '0;

   always_ff @(posedge CK or posedge RS) begin
      if (RS) begin
         state_q  <= StIdle;
         cnt_q    <= 4'd0;
         err_q    <= 1'b0;
         ack_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ack_q   <= ACK_NEXT;
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: DOUT is gated by COUNT.
   always_ff @(posedge CK) begin
      if (push) mem[wr_ptr_q] <= DIN;
   end

endmodule

// File: tb/tb_hs4_responder.sv
// Bench for hs4_responder: one instance with ACK_DELAY=0 (a) and one with ACK_DELAY=3 (b).
// Words offered to the initiator side are queued as expected; monitors pop and compare
// whenever a consumer handshake is presented.
module tb_hs4_responder;

   logic       ck, rs, ena;
   logic       req_a, rdy_a, ack_a, ackn_a, dv_a, err_a;
   logic       req_b, rdy_b, ack_b, ackn_b, dv_b, err_b;
   logic [7:0] din_a, dout_a, din_b, dout_b;
   logic [2:0] cnt_a, cnt_b;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   logic [7:0] e_a, e_b;
   int         max_cnt;

   hs4_responder #(.WIDTH(8), .DEPTH(4), .ACK_DELAY(0)) dut_a (
      .CK(ck), .RS(rs), .ENA(ena), .REQ(req_a), .DIN(din_a), .ACK(ack_a),
      .ACK_NEXT(ackn_a), .DOUT(dout_a), .DOUT_VALID(dv_a), .DOUT_READY(rdy_a),
      .COUNT(cnt_a), .ERR(err_a)
   );

   hs4_responder #(.WIDTH(8), .DEPTH(4), .ACK_DELAY(3)) dut_b (
      .CK(ck), .RS(rs), .ENA(ena), .REQ(req_b), .DIN(din_b), .ACK(ack_b),
      .ACK_NEXT(ackn_b), .DOUT(dout_b), .DOUT_VALID(dv_b), .DOUT_READY(rdy_b),
      .COUNT(cnt_b), .ERR(err_b)
   );

   initial begin
      ck = 1'b0;
      forever #5 ck = ~ck;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   // Consumer-side monitors: a pop happens at the next posedge when valid & ready.
   always @(negedge ck) begin
      if (!rs && dv_a && rdy_a) begin
         if (q_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_a: unexpected word %0h, none expected", dout_a);
         end else begin
            e_a = q_a.pop_front();
            chk("mon_a_data", {24'd0, dout_a}, {24'd0, e_a});
         end
      end
      if (!rs && dv_b && rdy_b) begin
         if (q_b.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_b: unexpected word %0h, none expected", dout_b);
         end else begin
            e_b = q_b.pop_front();
            chk("mon_b_data", {24'd0, dout_b}, {24'd0, e_b});
         end
      end
   end

   task automatic hs_a(input logic [7:0] d);
      req_a = 1'b1;
      din_a = d;
      q_a.push_back(d);
      step();
      req_a = 1'b0;
      step();
   endtask

   initial begin
      rs = 1'b1; ena = 1'b1;
      req_a = 0; rdy_a = 0; din_a = 0;
      req_b = 0; rdy_b = 0; din_b = 0;
      step();
      step();
      chk("rst_ack", ack_a, 0);
      chk("rst_cnt", cnt_a, 0);
      chk("rst_valid", dv_a, 0);
      chk("rst_dout", dout_a, 0);
      chk("rst_err", err_b, 0);
      rs = 1'b0;
      step();

      // Basic handshake, ACK_DELAY=0
      req_a = 1'b1; din_a = 8'hA5; q_a.push_back(8'hA5);
      step();
      chk("basic_ack_rise", ack_a, 1);
      chk("basic_valid", dv_a, 1);
      chk("basic_dout", dout_a, 8'hA5);
      chk("basic_cnt", cnt_a, 1);
      req_a = 1'b0;
      step();
      chk("basic_ack_fall", ack_a, 0);
      rdy_a = 1'b1;
      step();
      rdy_a = 1'b0;
      chk("basic_pop_cnt", cnt_a, 0);
      chk("basic_pop_valid", dv_a, 0);

      // Backpressure
      for (int i = 1; i <= 4; i++) hs_a(8'(i));
      chk("bp_full_cnt", cnt_a, 4);
      req_a = 1'b1; din_a = 8'h05; q_a.push_back(8'h05);
      step();
      chk("bp_withheld1", ack_a, 0);
      chk("bp_withheld_cnt", cnt_a, 4);
      step();
      chk("bp_withheld2", ack_a, 0);
      rdy_a = 1'b1;
      step();
      rdy_a = 1'b0;
      chk("bp_after_pop_ack", ack_a, 0);
      chk("bp_after_pop_cnt", cnt_a, 3);
      step();
      chk("bp_push_ack", ack_a, 1);
      chk("bp_push_cnt", cnt_a, 4);
      req_a = 1'b0;
      step();
      chk("bp_ack_fall", ack_a, 0);
      rdy_a = 1'b1;
      repeat (4) step();
      rdy_a = 1'b0;
      chk("bp_drained", cnt_a, 0);

      // ACK_DELAY=3: ACK rises on the fourth edge sampling REQ
      req_b = 1'b1; din_b = 8'h33; q_b.push_back(8'h33);
      step();
      chk("dly_e1", ack_b, 0);
      step();
      chk("dly_e2", ack_b, 0);
      chk("dly_e2_next", ackn_b, 0);
      step();
      chk("dly_e3", ack_b, 0);
      chk("dly_e3_next", ackn_b, 1);
      step();
      chk("dly_e4", ack_b, 1);
      req_b = 1'b0;
      step();
      chk("dly_fall", ack_b, 0);
      rdy_b = 1'b1;
      step();
      rdy_b = 1'b0;

      // Violation: REQ withdrawn during DELAY
      req_b = 1'b1; din_b = 8'h44; q_b.push_back(8'h44);
      step();
      chk("viol_pre_err", err_b, 0);
      req_b = 1'b0;
      step();
      chk("viol_err", err_b, 1);
      chk("viol_ack", ack_b, 0);
      chk("viol_cnt", cnt_b, 1);
      rdy_b = 1'b1;
      step();
      rdy_b = 1'b0;

      // Clean handshake; ERR stays set
      req_b = 1'b1; din_b = 8'h55; q_b.push_back(8'h55);
      repeat (4) step();
      chk("sticky_ack", ack_b, 1);
      chk("sticky_err", err_b, 1);
      req_b = 1'b0;
      step();
      rdy_b = 1'b1;
      step();
      rdy_b = 1'b0;

      // Enable freeze in DELAY
      req_b = 1'b1; din_b = 8'h66; q_b.push_back(8'h66);
      step();
      step();
      ena = 1'b0; rdy_b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("frz_ack", ack_b, 0);
         chk("frz_next", ackn_b, 0);
         chk("frz_cnt", cnt_b, 1);
         chk("frz_valid", dv_b, 0);
      end
      ena = 1'b1; rdy_b = 1'b0;
      step();
      chk("frz_resume1", ack_b, 0);
      step();
      chk("frz_resume2", ack_b, 1);
      req_b = 1'b0;
      step();
      rdy_b = 1'b1;
      step();
      rdy_b = 1'b0;
      step();
      chk("b_queue_empty", q_b.size(), 0);

      // Wrap-around streaming
      rdy_a = 1'b1;
      max_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         req_a = 1'b1; din_a = 8'h10 + 8'(i); q_a.push_back(8'h10 + 8'(i));
         step();
         if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
         req_a = 1'b0;
         step();
         if (int'(cnt_a) > max_cnt) max_cnt = int'(cnt_a);
      end
      rdy_a = 1'b0;
      chk("wrap_max_cnt", max_cnt, 1);
      chk("wrap_final_cnt", cnt_a, 0);
      chk("a_queue_empty", q_a.size(), 0);

      // Asynchronous reset with ACK=1, COUNT=3 (these words are lost)
      req_a = 1'b1; din_a = 8'h20; step(); req_a = 1'b0; step();
      req_a = 1'b1; din_a = 8'h21; step(); req_a = 1'b0; step();
      req_a = 1'b1; din_a = 8'h22; step();
      chk("arst_pre_ack", ack_a, 1);
      chk("arst_pre_cnt", cnt_a, 3);
      #2;
      rs = 1'b1;
      #1;
      chk("arst_ack", ack_a, 0);
      chk("arst_cnt", cnt_a, 0);
      chk("arst_valid", dv_a, 0);
      chk("arst_dout", dout_a, 0);
      chk("arst_err_b", err_b, 0);
      req_a = 1'b0;
      step();
      rs = 1'b0;
      step();
      chk("post_rst_cnt", cnt_a, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
